reflet_float_to_int_pipe: RTL and testbench
===========================================

# reflet_float_to_int_pipe

Three-stage pipelined floating-point to integer converter with valid/ready handshakes, selectable rounding, signed/unsigned targets, saturation and exception flags. It supersedes the combinational converter in the FPU datapath: it accepts one conversion per cycle, stalls cleanly under output backpressure, and reports IEEE-style status for the FPU flag register.

## Interface
- `float_size`, default 32: input float width. Supported values are 16, 32 and 64, giving exponent/mantissa widths 5/10, 8/23 and 11/52. Bias is 2^(e-1)-1.
- `int_size`, default 16: output integer width, 2 to 64.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: input transaction present.
- `in_ready` output 1: converter can accept an input this cycle.
- `float_in` input `float_size`: operand.
- `round_mode` input 2: 00 toward zero, 01 nearest-even, 10 toward −inf, 11 toward +inf.
- `unsigned_mode` input 1: 1 selects an unsigned target, 0 a two's-complement target.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts the result.
- `int_out` output `int_size`: converted integer.
- `flag_invalid` output 1: input was NaN or ±Inf.
- `flag_overflow` output 1: finite input, rounded result outside the target range.
- `flag_inexact` output 1: nonzero fraction discarded and no saturation occurred.

## Operation
- A transfer occurs when `in_valid && in_ready`. `round_mode` and `unsigned_mode` are captured with `float_in` and travel with the transaction.
- Stage 1, decode:
  - Extract sign, biased exponent and mantissa.
  - Classify the input as zero, subnormal, normal, Inf or NaN.
  - Compute the unbiased exponent in e+1 bits, signed.
- Stage 2, align:
  - Shift the significand {1, mantissa} (hidden bit 0 for subnormals) to integer position.
  - Keep `int_size`+1 integer bits, a guard bit and a sticky bit (OR of all bits below guard).
  - Exponents ≥ `int_size`+1 set a precomputed too-big bit.
  - Exponents < −1 yield integer 0, guard 0, sticky 1 if the input is nonzero.
- Stage 3, round and saturate:
  - Round-up decision:
    - RTZ: never.
    - RNE: guard && (sticky || lsb).
    - Floor: sign && (guard || sticky).
    - Ceil: !sign && (guard || sticky).
  - Add the round-up to the magnitude, apply the sign, then range-check.
  - Signed range is [−2^(int_size−1), 2^(int_size−1)−1]. Unsigned range is [0, 2^int_size−1].
- Special cases:
  - NaN: `int_out` = signed max (0x7FFF…) or unsigned max (all ones); `flag_invalid`.
  - +Inf: max of the target range; `flag_invalid`.
  - −Inf: signed min (0x800…) or unsigned 0; `flag_invalid`.
  - Finite value out of range: saturate to the nearer bound; `flag_overflow`.
  - Unsigned mode, negative input that rounds to 0 (e.g. −0.4 RTZ): result 0, `flag_inexact` only.
  - Unsigned mode, negative input that rounds to a nonzero value: result 0, `flag_overflow`.
  - ±0 gives 0 with no flags. A subnormal gives 0 or ±1 per rounding, with `flag_inexact`.
- Exactly −2^(int_size−1) in signed mode is exact: no flags.
- At most one flag is set per result.

## Timing
- Latency is 3 cycles from the accepting edge to `out_valid`. Throughput is 1 per cycle when `out_ready` is held high.
- Pipeline advance: `advance = !out_valid || out_ready`. `in_ready` = `advance`, combinational, and never depends on `in_valid`.
- When `advance` is low, all stages hold. `int_out`, the flags and `out_valid` stay stable until accepted.
- Internal bubbles are carried as stage-valid bits. A bubble in stage 3 yields `out_valid` = 0.
- Reset values: `out_valid` 0, all stage-valid bits 0, `int_out` 0, all flags 0. `in_ready` = 1 in the cycle after reset.
- Reset asserted mid-stream discards all in-flight transactions. No partial result is emitted after reset.
- Simultaneous events: a result accepted and a new input accepted in the same cycle is legal and required for full throughput.

## Test plan
- 0x40600000 (3.5), signed: RTZ → 3, `flag_inexact`; RNE → 4, `flag_inexact`. 0x40200000 (2.5) RNE → 2 (ties to even).
- 0xBFC00000 (−1.5): floor → 0xFFFE (−2); ceil → 0xFFFF (−1); RTZ → 0xFFFF (−1). All three set `flag_inexact`.
- 0x471C4000 (40000.0): signed → 0x7FFF with `flag_overflow`; unsigned → 0x9C40 with no flags. 0xC7000000 (−32768.0) signed → 0x8000 with no flags.
- Specials: 0x7FC00000 (NaN) → 0x7FFF with `flag_invalid`. 0xFF800000 (−Inf) signed → 0x8000 and unsigned → 0x0000, both with `flag_invalid`. 0x00000001 (subnormal) ceil → 1 with `flag_inexact`.
- Backpressure: inputs 1.0, 2.0, 3.0, 4.0, 5.0 sent back-to-back with `out_ready` low in cycles 4–7.
  - Required: `in_ready` drops while stalled; outputs 1–5 emerge in order with none lost or duplicated.
  - Required: `int_out` stays stable while `out_valid` is high and `out_ready` is low.
- Reset: `reset` asserted one cycle with 2 transactions in flight.
  - Required: `out_valid` = 0 and `int_out` = 0 on the next cycle; no stale result appears afterwards.
  - Required: a new input (−7.0, 0xC0E00000) returns 0xFFF9 exactly 3 cycles after acceptance.

Source files
------------

// File: rtl/reflet_float_to_int_pipe_if.sv
// Conversion request/result bundle for the float-to-int pipe.
// master issues operands and accepts results; slave is the converter.
interface reflet_float_to_int_pipe_if #(
    parameter int float_size = 32,
    parameter int int_size   = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [float_size-1:0] float_in;
    logic [1:0]            round_mode;
    logic                  unsigned_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [int_size-1:0]   int_out;
    logic                  flag_invalid;
    logic                  flag_overflow;
    logic                  flag_inexact;

    modport master (
        output in_valid, float_in, round_mode, unsigned_mode, out_ready,
        input  in_ready, out_valid, int_out, flag_invalid, flag_overflow, flag_inexact
    );

    modport slave (
        input  in_valid, float_in, round_mode, unsigned_mode, out_ready,
        output in_ready, out_valid, int_out, flag_invalid, flag_overflow, flag_inexact
    );
endinterface

// File: rtl/reflet_float_to_int_pipe.sv
// Float to signed/unsigned integer converter: decode, align, round/saturate.
// Latency 3 cycles, 1/cycle; a stalled output freezes every stage (in_ready = !out_valid || out_ready).
// Flags are mutually exclusive: invalid (NaN/Inf), overflow (saturated), inexact.
module reflet_float_to_int_pipe #(
    parameter int float_size = 32,
    parameter int int_size   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    reflet_float_to_int_pipe_if.slave     bus
);
    localparam int EW   = (float_size == 16) ? 5 : (float_size == 64) ? 11 : 8;
    localparam int MW   = float_size - 1 - EW;
    localparam int EXPW = EW + 1;
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int IW   = int_size + 1;
    localparam int FW   = MW + 1;
    localparam int XW   = IW + FW;
    localparam int MAGW = int_size + 2;

    localparam logic [MAGW-1:0]     ONE      = MAGW'(1);
    localparam logic [MAGW-1:0]     LIM_NEG  = ONE << (int_size - 1);
    localparam logic [MAGW-1:0]     LIM_SPOS = LIM_NEG - ONE;
    localparam logic [MAGW-1:0]     LIM_UPOS = (ONE << int_size) - ONE;
    localparam logic [int_size-1:0] SMAX     = {1'b0, {(int_size-1){1'b1}}};
    localparam logic [int_size-1:0] SMIN     = {1'b1, {(int_size-1){1'b0}}};
    localparam logic [int_size-1:0] UMAX     = '1;

    localparam logic [1:0] RM_RTZ  = 2'b00;
    localparam logic [1:0] RM_RNE  = 2'b01;
    localparam logic [1:0] RM_DOWN = 2'b10;

    logic                   s1_vld_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q, s1_uns_q;
    logic [1:0]             s1_rm_q;
    logic signed [EW:0]     s1_exp_q;
    logic [MW:0]            s1_sig_q;
    logic                   s2_vld_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_uns_q;
    logic                   s2_big_q, s2_grd_q, s2_stk_q;
    logic [1:0]             s2_rm_q;
    logic [IW-1:0]          s2_int_q;
    logic                   out_vld_q, inv_q, ovf_q, inx_q;
    logic [int_size-1:0]    int_out_q;

    logic advance;
    assign advance      = !out_vld_q || bus.out_ready;
    assign bus.in_ready = advance;

    // Stage 1: field extraction and classification
    logic [EW-1:0]      fexp;
    logic [MW-1:0]      fman;
    logic               exp_max, exp_zero, man_zero;
    logic               s1_nan_d, s1_inf_d, s1_zero_d;
    logic signed [EW:0] s1_exp_d;
    logic [MW:0]        s1_sig_d;

    always_comb begin
        fexp      = bus.float_in[float_size-2:MW];
        fman      = bus.float_in[MW-1:0];
        exp_max   = &fexp;
        exp_zero  = ~|fexp;
        man_zero  = ~|fman;
        s1_nan_d  = exp_max && !man_zero;
        s1_inf_d  = exp_max && man_zero;
        s1_zero_d = exp_zero && man_zero;
        // Subnormals share the minimum normal exponent with a zero hidden bit
        s1_exp_d  = EXPW'((exp_zero ? 1 : int'(fexp)) - BIAS);
        s1_sig_d  = {!exp_zero, fman};
    end

    // Stage 2: place the binary point so the guard bit sits just below the integer lsb
    int             exp_i;
    logic [7:0]     shamt;
    logic [XW-1:0]  aligned;
    logic           s2_big_d, s2_grd_d, s2_stk_d;
    logic [IW-1:0]  s2_int_d;

    always_comb begin
        exp_i    = int'(s1_exp_q);
        shamt    = '0;
        aligned  = '0;
        s2_int_d = '0;
        s2_grd_d = 1'b0;
        s2_stk_d = 1'b0;
        s2_big_d = (exp_i >= IW);
        if (exp_i < -1) begin
            s2_stk_d = !s1_zero_q;
        end else if (!s2_big_d) begin
            shamt    = 8'(exp_i + 1);
            aligned  = XW'(s1_sig_q) << shamt;
            s2_int_d = aligned[XW-1:FW];
            s2_grd_d = aligned[FW-1];
            s2_stk_d = |aligned[FW-2:0];
        end
    end

    // Stage 3: round the magnitude, then apply sign and range limits
    logic                frac, up;
    logic [MAGW-1:0]     mag, neg;
    logic [int_size-1:0] res_d;
    logic                inv_d, ovf_d, inx_d;

    always_comb begin
        frac = s2_grd_q || s2_stk_q;
        case (s2_rm_q)
            RM_RTZ:  up = 1'b0;
            RM_RNE:  up = s2_grd_q && (s2_stk_q || s2_int_q[0]);
            RM_DOWN: up = s2_sign_q && frac;
            default: up = !s2_sign_q && frac;
        endcase
        mag   = {1'b0, s2_int_q} + MAGW'(up);
        neg   = -mag;
        res_d = '0;
        inv_d = 1'b0;
        ovf_d = 1'b0;
        inx_d = 1'b0;
        if (s2_nan_q) begin
            res_d = s2_uns_q ? UMAX : SMAX;
            inv_d = 1'b1;
        end else if (s2_inf_q) begin
            res_d = s2_sign_q ? (s2_uns_q ? '0 : SMIN) : (s2_uns_q ? UMAX : SMAX);
            inv_d = 1'b1;
        end else if (s2_uns_q) begin
            if (s2_sign_q) begin
                ovf_d = s2_big_q || (mag != '0);
                inx_d = !ovf_d && frac;
            end else if (s2_big_q || mag > LIM_UPOS) begin
                res_d = UMAX;
                ovf_d = 1'b1;
            end else begin
                res_d = mag[int_size-1:0];
                inx_d = frac;
            end
        end else if (s2_sign_q) begin
            if (s2_big_q || mag > LIM_NEG) begin
                res_d = SMIN;
                ovf_d = 1'b1;
            end else begin
                res_d = neg[int_size-1:0];
                inx_d = frac;
            end
        end else if (s2_big_q || mag > LIM_SPOS) begin
            res_d = SMAX;
            ovf_d = 1'b1;
        end else begin
            res_d = mag[int_size-1:0];
            inx_d = frac;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_nan_q  <= 1'b0;
            s1_inf_q  <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_uns_q  <= 1'b0;
            s1_rm_q   <= '0;
            s1_exp_q  <= '0;
            s1_sig_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_nan_q  <= 1'b0;
            s2_inf_q  <= 1'b0;
            s2_uns_q  <= 1'b0;
            s2_big_q  <= 1'b0;
            s2_grd_q  <= 1'b0;
            s2_stk_q  <= 1'b0;
            s2_rm_q   <= '0;
            s2_int_q  <= '0;
            out_vld_q <= 1'b0;
            int_out_q <= '0;
            inv_q     <= 1'b0;
            ovf_q     <= 1'b0;
            inx_q     <= 1'b0;
        end else if (advance) begin
            s1_vld_q  <= bus.in_valid;
            s1_sign_q <= bus.float_in[float_size-1];
            s1_nan_q  <= s1_nan_d;
            s1_inf_q  <= s1_inf_d;
            s1_zero_q <= s1_zero_d;
            s1_uns_q  <= bus.unsigned_mode;
            s1_rm_q   <= bus.round_mode;
            s1_exp_q  <= s1_exp_d;
            s1_sig_q  <= s1_sig_d;
            s2_vld_q  <= s1_vld_q;
            s2_sign_q <= s1_sign_q;
            s2_nan_q  <= s1_nan_q;
            s2_inf_q  <= s1_inf_q;
            s2_uns_q  <= s1_uns_q;
            s2_big_q  <= s2_big_d;
            s2_grd_q  <= s2_grd_d;
            s2_stk_q  <= s2_stk_d;
            s2_rm_q   <= s1_rm_q;
            s2_int_q  <= s2_int_d;
            out_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                int_out_q <= res_d;
                inv_q     <= inv_d;
                ovf_q     <= ovf_d;
                inx_q     <= inx_d;
            end
        end
    end

    assign bus.out_valid     = out_vld_q;
    assign bus.int_out       = int_out_q;
    assign bus.flag_invalid  = inv_q;
    assign bus.flag_overflow = ovf_q;
    assign bus.flag_inexact  = inx_q;
endmodule

// File: tb/tb_reflet_float_to_int_pipe.sv
// Directed bench for reflet_float_to_int_pipe (fp32 -> 16-bit): vectors, backpressure, mid-stream reset.
module tb_reflet_float_to_int_pipe;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    reflet_float_to_int_pipe_if #(.float_size(32), .int_size(16)) bus ();

    reflet_float_to_int_pipe #(.float_size(32), .int_size(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f;
        logic [1:0]  rm;
        logic        uns;
        logic [15:0] res;
        logic [2:0]  flg;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] bp_in[5];
    logic [15:0] got[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] flags_now();
        return {bus.flag_invalid, bus.flag_overflow, bus.flag_inexact};
    endfunction

    task automatic convert(input string tag, input vec_t v);
        int lat;
        bit seen;
        @(negedge clk);
        bus.in_valid      = 1'b1;
        bus.float_in      = v.f;
        bus.round_mode    = v.rm;
        bus.unsigned_mode = v.uns;
        bus.out_ready     = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (bus.out_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!seen) begin
            check($sformatf("%s_timeout", tag), 64'd0, 64'd1);
        end else begin
            check($sformatf("%s_lat", tag), 64'(lat), 64'd3);
            check($sformatf("%s_int", tag), 64'(bus.int_out), 64'(v.res));
            check($sformatf("%s_flg", tag), 64'(flags_now()), 64'(v.flg));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          prev_stall;
        int          sent;
        int          stall_lo;
        int          stale;
        logic [15:0] held;
        vec_t        v7;

        checks   = 0;
        failures = 0;
        held     = '0;
        reset             = 1'b1;
        bus.in_valid      = 1'b0;
        bus.float_in      = '0;
        bus.round_mode    = '0;
        bus.unsigned_mode = 1'b0;
        bus.out_ready     = 1'b1;

        //               f              rm    uns   res       flags {inv,ovf,inx}
        vecs.push_back('{32'h40600000, 2'd0, 1'b0, 16'h0003, 3'b001}); // 3.5 rtz
        vecs.push_back('{32'h40600000, 2'd1, 1'b0, 16'h0004, 3'b001}); // 3.5 rne
        vecs.push_back('{32'h40200000, 2'd1, 1'b0, 16'h0002, 3'b001}); // 2.5 rne tie-even
        vecs.push_back('{32'hBFC00000, 2'd2, 1'b0, 16'hFFFE, 3'b001}); // -1.5 floor
        vecs.push_back('{32'hBFC00000, 2'd3, 1'b0, 16'hFFFF, 3'b001}); // -1.5 ceil
        vecs.push_back('{32'hBFC00000, 2'd0, 1'b0, 16'hFFFF, 3'b001}); // -1.5 rtz
        vecs.push_back('{32'h471C4000, 2'd0, 1'b0, 16'h7FFF, 3'b010}); // 40000 signed
        vecs.push_back('{32'h471C4000, 2'd0, 1'b1, 16'h9C40, 3'b000}); // 40000 unsigned
        vecs.push_back('{32'hC7000000, 2'd0, 1'b0, 16'h8000, 3'b000}); // -32768 exact
        vecs.push_back('{32'h7FC00000, 2'd0, 1'b0, 16'h7FFF, 3'b100}); // NaN signed
        vecs.push_back('{32'h7FC00000, 2'd0, 1'b1, 16'hFFFF, 3'b100}); // NaN unsigned
        vecs.push_back('{32'hFF800000, 2'd0, 1'b0, 16'h8000, 3'b100}); // -Inf signed
        vecs.push_back('{32'hFF800000, 2'd0, 1'b1, 16'h0000, 3'b100}); // -Inf unsigned
        vecs.push_back('{32'h7F800000, 2'd1, 1'b0, 16'h7FFF, 3'b100}); // +Inf signed
        vecs.push_back('{32'h00000001, 2'd3, 1'b0, 16'h0001, 3'b001}); // subnormal ceil
        vecs.push_back('{32'h80000001, 2'd2, 1'b0, 16'hFFFF, 3'b001}); // -subnormal floor
        vecs.push_back('{32'h00000000, 2'd1, 1'b0, 16'h0000, 3'b000}); // +0
        vecs.push_back('{32'h80000000, 2'd2, 1'b1, 16'h0000, 3'b000}); // -0 unsigned floor
        vecs.push_back('{32'hBECCCCCD, 2'd0, 1'b1, 16'h0000, 3'b001}); // -0.4 unsigned rtz
        vecs.push_back('{32'hBECCCCCD, 2'd2, 1'b1, 16'h0000, 3'b010}); // -0.4 unsigned floor
        vecs.push_back('{32'hBECCCCCD, 2'd1, 1'b0, 16'h0000, 3'b001}); // -0.4 signed rne
        vecs.push_back('{32'h477FFF00, 2'd0, 1'b1, 16'hFFFF, 3'b000}); // 65535 unsigned
        vecs.push_back('{32'h477FFF80, 2'd1, 1'b1, 16'hFFFF, 3'b010}); // 65535.5 rne overflows
        vecs.push_back('{32'h477FFF80, 2'd0, 1'b1, 16'hFFFF, 3'b001}); // 65535.5 rtz
        vecs.push_back('{32'hC7000080, 2'd0, 1'b0, 16'h8000, 3'b001}); // -32768.5 rtz
        vecs.push_back('{32'hC7000080, 2'd2, 1'b0, 16'h8000, 3'b010}); // -32768.5 floor
        vecs.push_back('{32'h3F000000, 2'd1, 1'b0, 16'h0000, 3'b001}); // 0.5 rne
        vecs.push_back('{32'h3F000000, 2'd3, 1'b0, 16'h0001, 3'b001}); // 0.5 ceil
        vecs.push_back('{32'h501502F9, 2'd0, 1'b0, 16'h7FFF, 3'b010}); // 1e10 signed
        vecs.push_back('{32'hD01502F9, 2'd0, 1'b1, 16'h0000, 3'b010}); // -1e10 unsigned

        bp_in[0] = 32'h3F800000;
        bp_in[1] = 32'h40000000;
        bp_in[2] = 32'h40400000;
        bp_in[3] = 32'h40800000;
        bp_in[4] = 32'h40A00000;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_int_out", 64'(bus.int_out), 64'd0);
        check("rst_flags", 64'(flags_now()), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        foreach (vecs[i]) convert($sformatf("vec%0d", i), vecs[i]);

        // Back-to-back 1.0..5.0 with the consumer stalled in cycles 4-7
        sent       = 0;
        stall_lo   = 0;
        prev_stall = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            bus.out_ready     = !(c >= 4 && c <= 7);
            bus.in_valid      = (sent < 5);
            bus.float_in      = bp_in[(sent < 5) ? sent : 0];
            bus.round_mode    = 2'd0;
            bus.unsigned_mode = 1'b0;
            #1;
            if (prev_stall) begin
                check("bp_hold_vld", 64'(bus.out_valid), 64'd1);
                check("bp_hold_int", 64'(bus.int_out), 64'(held));
            end
            if (bus.out_valid && !bus.out_ready) begin
                check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
                stall_lo++;
                held       = bus.int_out;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) got.push_back(bus.int_out);
            if (bus.in_valid && bus.in_ready) sent++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_stall_cycles", 64'(stall_lo), 64'd4);
        check("bp_count", 64'(got.size()), 64'd5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            check($sformatf("bp_order%0d", i), 64'(got[i]), 64'(i + 1));

        // Reset with two conversions in flight
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.float_in   = 32'h40000000;
        bus.round_mode = 2'd0;
        @(negedge clk);
        bus.float_in = 32'h40400000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_int_out", 64'(bus.int_out), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("midrst_stale", 64'(stale), 64'd0);
        v7 = '{32'hC0E00000, 2'd0, 1'b0, 16'hFFF9, 3'b000};
        convert("post_rst_m7", v7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
